cla_pipe_adder: RTL and testbench

//   Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 16-bit
//   4x4-bit CLA. Splits a WIDTH-bit add into WIDTH/BLK lookahead blocks, one block per

---
 rtl/cla_pipe_adder.sv | 152 +++++++++++++++
 tb/tb_cla_pipe_adder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLK-bit lookahead block per stage, carry
// registered between stages, global-stall valid/ready flow control, latency NBLK cycles.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] Q,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int NBLK = WIDTH / BLK;

  if ((BLK < 1) || ((WIDTH % ((BLK < 1) ? 1 : BLK)) != 0)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a positive multiple of BLK");
  end

  // Carries c[0..BLK] of one block, each written as the flattened generate/propagate sum.
  function automatic logic [BLK:0] cla_carries(input logic [BLK-1:0] g,
                                               input logic [BLK-1:0] p,
                                               input logic           cin);
    logic [BLK:0] c;
    logic         term;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLK; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  // Stage k holds a beat waiting for block k to be resolved.
  logic [NBLK-1:0]  vld_q, vld_d;
  logic [NBLK-1:0]  c_q, c_d;
  logic [WIDTH-1:0] a_q [NBLK];
  logic [WIDTH-1:0] a_d [NBLK];
  logic [WIDTH-1:0] b_q [NBLK];
  logic [WIDTH-1:0] b_d [NBLK];
  logic [WIDTH-1:0] s_q [NBLK];
  logic [WIDTH-1:0] s_d [NBLK];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [BLK:0]     car  [NBLK];
  logic [BLK-1:0]   bsum [NBLK];
  logic [WIDTH-1:0] fsum;
  logic             adv;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic [BLK-1:0] ab, bb;
    assign ab      = a_q[k][k*BLK +: BLK];
    assign bb      = b_q[k][k*BLK +: BLK];
    assign car[k]  = cla_carries(ab & bb, ab ^ bb, c_q[k]);
    assign bsum[k] = (ab ^ bb) ^ car[k][BLK-1:0];
  end

  assign adv      = !out_valid_q | out_ready;
  assign in_ready = adv;

  always_comb begin
    vld_d       = vld_q;
    c_d         = c_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    fsum        = s_q[NBLK-1];
    fsum[(NBLK-1)*BLK +: BLK] = bsum[NBLK-1];
    if (adv) begin
      vld_d[0] = in_valid;
      a_d[0]   = P;
      b_d[0]   = Sub ? ~Q : Q;
      c_d[0]   = Sub | Cin;
      s_d[0]   = '0;
      for (int k = 0; k < NBLK - 1; k++) begin
        vld_d[k+1] = vld_q[k];
        a_d[k+1]   = a_q[k];
        b_d[k+1]   = b_q[k];
        c_d[k+1]   = car[k][BLK];
        s_d[k+1]   = s_q[k];
        s_d[k+1][k*BLK +: BLK] = bsum[k];
      end
      out_valid_d = vld_q[NBLK-1];
      // Result registers only move when a real beat lands; bubbles leave them holding.
      if (vld_q[NBLK-1]) begin
        sum_d  = fsum;
        cout_d = car[NBLK-1][BLK];
        ovf_d  = car[NBLK-1][BLK] ^ car[NBLK-1][BLK-1];
        zero_d = (fsum == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      c_q         <= '0;
      for (int k = 0; k < NBLK; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      c_q         <= c_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: cycle model of the pipe valids plus a result scoreboard queue.
module tb_cla_pipe_adder;
  localparam int W    = 16;
  localparam int NBLK = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, Cin, Sub;
  logic          out_valid, out_ready, Cout, Ovf, Zero;
  logic [W-1:0]  P, Q, Sum;

  cla_pipe_adder #(.WIDTH(W), .BLK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .P(P), .Q(Q), .Cin(Cin), .Sub(Sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf), .Zero(Zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [18:0]     sb[$];
  logic [NBLK-1:0] mv    = '0;
  logic            mov   = 1'b0;
  logic [18:0]     mcur  = '0;
  logic            armed = 1'b0;
  logic            use_dir = 1'b0;
  logic [18:0]     dir_exp = '0;
  logic            rand_ordy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {sum, cout, ovf, zero}; overflow from operand/result sign rule.
  function automatic logic [18:0] ref_model(input logic [W-1:0] p, input logic [W-1:0] q,
                                            input logic cin, input logic sub);
    logic [W-1:0] b;
    logic [W:0]   t;
    logic         ov;
    b  = sub ? ~q : q;
    t  = {1'b0, p} + {1'b0, b} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    ov = (p[W-1] == b[W-1]) && (t[W-1] != p[W-1]);
    return {t[W-1:0], t[W], ov, (t[W-1:0] == '0)};
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!mov || out_ready)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, mov});
      chk("result", {13'd0, Sum, Cout, Ovf, Zero}, {13'd0, mcur});
    end
    if (rst) begin
      mv = '0; mov = 1'b0; mcur = '0; sb.delete(); armed = 1'b1;
    end else if (armed && (!mov || out_ready)) begin
      if (mv[NBLK-1]) mcur = sb.pop_front();
      mov = mv[NBLK-1];
      mv  = {mv[NBLK-2:0], in_valid};
      if (in_valid) sb.push_back(use_dir ? dir_exp : ref_model(P, Q, Cin, Sub));
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rand_ordy ? 1'($urandom % 2) : 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic send(input logic [W-1:0] p, input logic [W-1:0] q, input logic cin,
                      input logic sub, input logic udir, input logic [18:0] dexp);
    logic took;
    int   n;
    P = p; Q = q; Cin = cin; Sub = sub; use_dir = udir; dir_exp = dexp;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!took && n < 1000);
    checks++;
    assert (took) else begin
      fails++;
      $error("FAIL accept_timeout observed=%0d expected=1", took);
    end
    use_dir = 1'b0;
  endtask

  task automatic send_rand();
    send(W'($urandom), W'($urandom), 1'($urandom % 2), 1'($urandom % 2), 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; P = 16'h1234; Q = 16'h0042; Cin = 1'b0; Sub = 1'b0;
    cyc(); cyc();
    rst = 1'b0; in_valid = 1'b0;
    idle(6);

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {16'h8000, 1'b0, 1'b1, 1'b0});
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0, 1'b0});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0});
    send(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1});
    idle(8);

    for (int i = 0; i < 200; i++) send_rand();
    idle(8);

    rand_ordy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom % 2 == 0) send_rand();
      else idle(1);
    end
    rand_ordy = 1'b0;
    idle(12);

    for (int i = 0; i < 3; i++) send_rand();
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle(8);
    send(16'hA5A5, 16'h1111, 1'b1, 1'b0, 1'b0, '0);
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
